// File: rtl/jt1943_objbus.sv
// Purpose: CPU-side responder for the object DMA: OKOUT request latch, BUSRQ/BUSAK bus handover, work-RAM mux.
// Latency: OKOUT 1 clk after okout_wr; cpu_busrq 1 cen6 tick after bus_req; bus_ack SYNC+1 ticks after steady cpu_busak.
// Backpressure: the DMA waits on bus_ack; the CPU is held off through cpu_busrq until it answers with cpu_busak.
//
// Ports:
//   clk, rst_n, cen6         clock, async active-low reset, 6 MHz enable
//   LVBL, okout_wr           vertical blank (active-low), CPU strobe to OKOUT address
//   cpu_AB/cpu_dout/cpu_ram_we  CPU side of the work RAM
//   cpu_busrq/cpu_busak      bus request to the CPU and its acknowledge
//   OKOUT/bus_req/bus_ack    DMA start request, DMA bus request, bus grant
//   blen/obj_AB/DB           DMA address valid, DMA address, registered read data
//   ram_addr/ram_din/ram_we/ram_dout  work RAM port
//   stall                    saturating count of ticks spent waiting in REQ
module jt1943_objbus #(
    parameter int SYNC   = 2,
    parameter int STALLW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen6,
    input  logic              LVBL,
    input  logic              okout_wr,
    input  logic [12:0]       cpu_AB,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_ram_we,
    output logic              cpu_busrq,
    input  logic              cpu_busak,
    output logic              OKOUT,
    input  logic              bus_req,
    output logic              bus_ack,
    input  logic              blen,
    input  logic [12:0]       obj_AB,
    output logic [7:0]        DB,
    output logic [12:0]       ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we,
    input  logic [7:0]        ram_dout,
    output logic [STALLW-1:0] stall
);

    localparam int SW = $clog2(SYNC + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     sync_cnt, sync_nx;
    logic              busrq_nx, ack_nx;
    logic [STALLW-1:0] stall_nx;
    logic              lvbl_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sync_cnt  <= '0;
            cpu_busrq <= 1'b0;
            bus_ack   <= 1'b0;
            stall     <= '0;
        end else if (cen6) begin
            state     <= state_nx;
            sync_cnt  <= sync_nx;
            cpu_busrq <= busrq_nx;
            bus_ack   <= ack_nx;
            stall     <= stall_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sync_nx  = sync_cnt;
        busrq_nx = cpu_busrq;
        ack_nx   = bus_ack;
        stall_nx = stall;
        case (state)
            IDLE: begin
                if (bus_req) begin
                    state_nx = REQ;
                    busrq_nx = 1'b1;
                    stall_nx = '0;
                    sync_nx  = '0;
                end
            end
            REQ: begin
                stall_nx = (&stall) ? stall : stall + STALLW'(1);
                // A dropped request wins over a grant that would land on the same tick.
                if (!bus_req) begin
                    state_nx = RELEASE;
                    busrq_nx = 1'b0;
                    sync_nx  = '0;
                end else if (sync_cnt == SW'(SYNC)) begin
                    state_nx = GRANT;
                    ack_nx   = 1'b1;
                    sync_nx  = '0;
                end else begin
                    // Any low sample of cpu_busak restarts the debounce.
                    sync_nx = cpu_busak ? sync_cnt + SW'(1) : '0;
                end
            end
            GRANT: begin
                if (!bus_req) begin
                    state_nx = RELEASE;
                    ack_nx   = 1'b0;
                    busrq_nx = 1'b0;
                end
            end
            RELEASE: begin
                // New requests wait here until the CPU has really taken the bus back.
                if (!cpu_busak) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // OKOUT: set from the CPU strobe on any clk; set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OKOUT  <= 1'b0;
            lvbl_l <= 1'b1;
        end else begin
            if (okout_wr)
                OKOUT <= 1'b1;
            else if (cen6 && (bus_req || (LVBL && !lvbl_l)))
                OKOUT <= 1'b0;
            if (cen6) lvbl_l <= LVBL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) DB <= '0;
        else        DB <= ram_dout;
    end

    // CPU writes are blocked for the whole grant, not only while blen is high.
    always_comb begin
        ram_din = cpu_dout;
        if (bus_ack && blen) begin
            ram_addr = obj_AB;
            ram_we   = 1'b0;
        end else begin
            ram_addr = cpu_AB;
            ram_we   = cpu_ram_we & ~bus_ack;
        end
    end

endmodule

// File: tb/tb_jt1943_objbus.sv
module tb_jt1943_objbus;

    localparam int SYNC   = 2;
    localparam int STALLW = 8;

    logic              clk, rst_n, cen6, LVBL, okout_wr;
    logic [12:0]       cpu_AB, obj_AB, ram_addr;
    logic [7:0]        cpu_dout, DB, ram_din, ram_dout;
    logic              cpu_ram_we, cpu_busrq, cpu_busak, OKOUT, bus_req, bus_ack, blen, ram_we;
    logic [STALLW-1:0] stall;

    jt1943_objbus #(.SYNC(SYNC), .STALLW(STALLW)) dut (
        .clk(clk), .rst_n(rst_n), .cen6(cen6), .LVBL(LVBL), .okout_wr(okout_wr),
        .cpu_AB(cpu_AB), .cpu_dout(cpu_dout), .cpu_ram_we(cpu_ram_we),
        .cpu_busrq(cpu_busrq), .cpu_busak(cpu_busak), .OKOUT(OKOUT),
        .bus_req(bus_req), .bus_ack(bus_ack), .blen(blen), .obj_AB(obj_AB), .DB(DB),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .stall(stall)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // cen6 is high for one posedge out of every four.
    initial begin
        cen6 = 0;
        forever begin
            repeat (3) @(posedge clk);
            #1 cen6 = 1;
            @(posedge clk);
            #1 cen6 = 0;
        end
    end

    // Synchronous work RAM, one clk read latency.
    logic [7:0] mem     [8192];
    logic [7:0] ref_mem [8192];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        bit granted;
        int st;
    } rel_t;

    int         q_ok[$];
    int         q_grant[$];
    rel_t       q_rel[$];
    logic [7:0] q_db[$];
    bit         ak_seq[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns to just after the next cen6 edge.
    task automatic wait_tick();
        @(posedge clk);
        while (cen6 !== 1'b1) @(posedge clk);
        #2;
    endtask

    // Reference: REQ tick k (1-based) on which the request ends. A drop on tick k aborts;
    // otherwise a grant happens on the first tick preceded by SYNC consecutive busak-high ticks.
    function automatic int req_end(input int drop, output bit granted);
        bit win;
        granted = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (k == drop) return k;
            win = (k > SYNC);
            for (int j = k - SYNC; j < k && win; j++)
                if (j < 1 || j > ak_seq.size() || !ak_seq[j-1]) win = 0;
            if (win) begin
                granted = 1;
                return k;
            end
        end
        return -1;
    endfunction

    task automatic cpu_write(input logic [12:0] a, input logic [7:0] d);
        cpu_AB = a; cpu_dout = d; cpu_ram_we = 1;
        @(posedge clk);
        #2 cpu_ram_we = 0;
        ref_mem[a] = d;
    endtask

    task automatic okout_pulse();
        okout_wr = 1;
        @(posedge clk);
        #2 okout_wr = 0;
    endtask

    task automatic do_request(input int drop, input int nreads, input bit wr_try,
                              input bit ok_in_grant, input bit rst_mid, input logic [12:0] a0);
        bit   g;
        int   kend, st;
        rel_t r;
        kend = req_end(drop, g);
        st   = (kend > 255) ? 255 : kend;
        if (g) q_grant.push_back(kend);
        if (!rst_mid) begin
            r.granted = g; r.st = st;
            q_rel.push_back(r);
        end
        bus_req = 1;
        wait_tick();
        for (int k = 1; k <= kend; k++) begin
            cpu_busak = (k <= ak_seq.size()) ? ak_seq[k-1] : 1'b0;
            if (k == drop) bus_req = 0;
            wait_tick();
        end
        if (g) begin
            cpu_busak = 1;
            if (rst_mid) begin
                okout_pulse();
                check("okout_before_reset", OKOUT, 1);
                rst_n = 0;
                #1;
                check("reset_bus_ack", bus_ack, 0);
                check("reset_cpu_busrq", cpu_busrq, 0);
                check("reset_okout", OKOUT, 0);
                check("reset_stall", stall, 0);
                bus_req = 0; cpu_busak = 0;
                @(posedge clk);
                #2 rst_n = 1;
                wait_tick(); wait_tick();
                return;
            end
            if (ok_in_grant) begin
                // okout_wr lands on the same edge where bus_req would clear OKOUT.
                q_ok.push_back(1);
                repeat (3) @(posedge clk);
                #2 okout_wr = 1;
                @(posedge clk);
                #2 okout_wr = 0;
            end
            if (wr_try) begin
                cpu_AB = a0; cpu_dout = ~ref_mem[a0]; cpu_ram_we = 1;
                @(posedge clk);
                #2 cpu_ram_we = 0;
            end
            for (int n = 0; n < nreads; n++) begin
                logic [12:0] a;
                a = (n == 0) ? a0 : 13'($urandom);
                obj_AB = a; blen = 1;
                q_db.push_back(ref_mem[a]);
                if (wr_try) begin
                    cpu_AB = a; cpu_dout = ~ref_mem[a]; cpu_ram_we = 1;
                    @(posedge clk);
                    #2 cpu_ram_we = 0;
                end
                wait_tick();
            end
            if (wr_try) begin
                obj_AB = a0; blen = 1;
                q_db.push_back(ref_mem[a0]);
                wait_tick();
            end
            bus_req = 0; blen = 0;
            wait_tick();
        end
        cpu_busak = 0;
        wait_tick();
        wait_tick();
    endtask

    // Monitor: pops expectations when the DUT presents an event.
    initial begin : monitor
        logic cen_prev, tk, ack_p, rq_p, ok_p, breq_p, wr_p, seen_grant;
        int   ok_t, rq_t, brr_t, brf_t, e;
        rel_t r;
        cen_prev = 0; ack_p = 0; rq_p = 0; ok_p = 0; breq_p = 0; wr_p = 0; seen_grant = 0;
        ok_t = 0; rq_t = 0; brr_t = 0; brf_t = 0;
        forever begin
            @(negedge clk);
            tk = cen_prev;
            cen_prev = cen6;
            if (tk) begin ok_t++; rq_t++; brr_t++; brf_t++; end
            if (bus_req && !breq_p) brr_t = 0;
            if (!bus_req && breq_p) brf_t = 0;
            if (rst_n) begin
                if (OKOUT && !ok_p) begin
                    ok_t = 0;
                    check("okout_set_latency", wr_p, 1);
                end
                if (!OKOUT && ok_p) begin
                    check("okout_clear_expected", q_ok.size() > 0, 1);
                    if (q_ok.size() > 0) begin
                        e = q_ok.pop_front();
                        check("okout_clear_ticks", ok_t, e);
                    end
                end
                if (cpu_busrq && !rq_p) begin
                    rq_t = 0; seen_grant = 0;
                    check("busrq_latency", brr_t, 1);
                end
                if (bus_ack && !ack_p) begin
                    seen_grant = 1;
                    check("grant_expected", q_grant.size() > 0, 1);
                    if (q_grant.size() > 0) begin
                        e = q_grant.pop_front();
                        check("grant_ticks", rq_t, e);
                        check("stall_at_grant", stall, e);
                    end
                end
                if (!cpu_busrq && rq_p) begin
                    check("release_expected", q_rel.size() > 0, 1);
                    if (q_rel.size() > 0) begin
                        r = q_rel.pop_front();
                        check("release_granted", seen_grant, r.granted);
                        check("release_stall", stall, r.st);
                        check("release_latency", brf_t, 1);
                        check("release_ack_low", bus_ack, 0);
                    end
                end
                // The DMA samples DB on the coming cen6 edge.
                if (cen6 && bus_ack && blen) begin
                    check("db_expected", q_db.size() > 0, 1);
                    if (q_db.size() > 0) begin
                        e = q_db.pop_front();
                        check("db_data", DB, e);
                    end
                end
            end else begin
                seen_grant = 0;
            end
            ack_p = bus_ack; rq_p = cpu_busrq; ok_p = OKOUT; breq_p = bus_req; wr_p = okout_wr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        int          kend, drop, gap;
        bit          g;
        logic [12:0] a;
        rst_n = 1; LVBL = 1; okout_wr = 0; cpu_AB = 0; cpu_dout = 0; cpu_ram_we = 0;
        cpu_busak = 0; bus_req = 0; blen = 0; obj_AB = 0;
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[13'h1234] = 8'hA5; ref_mem[13'h1234] = 8'hA5;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busrq", cpu_busrq, 0);
        check("rst_okout", OKOUT, 0);
        check("rst_bus_ack", bus_ack, 0);
        check("rst_db", DB, 0);
        check("rst_stall", stall, 0);
        rst_n = 1;
        wait_tick(); wait_tick();

        // Normal DMA: OKOUT, bus_req two ticks later, busak high from the third REQ tick.
        q_ok.push_back(3);
        okout_pulse();
        wait_tick(); wait_tick();
        ak_seq = {0, 0, 1, 1};
        do_request(0, 2, 1, 1, 0, 13'h1234);

        // Glitching busak.
        ak_seq = {0, 0, 1, 0, 1, 1};
        do_request(0, 1, 0, 0, 0, 13'h0042);

        // Abort in REQ.
        ak_seq = {0, 1};
        do_request(3, 0, 0, 0, 0, 13'h0);

        // OKOUT cleared by LVBL rising edge.
        q_ok.push_back(3);
        LVBL = 0;
        okout_pulse();
        wait_tick(); wait_tick();
        LVBL = 1;
        wait_tick(); wait_tick();

        // Stall saturation.
        ak_seq = {};
        do_request(301, 0, 0, 0, 0, 13'h0);

        // Reset during a grant, then a normal request from IDLE.
        ak_seq = {1, 1};
        do_request(0, 0, 0, 0, 1, 13'h0);
        ak_seq = {1, 1};
        do_request(0, 1, 0, 0, 0, 13'h1234);

        // Randomized requests.
        for (int it = 0; it < 14; it++) begin
            for (int w = 0; w < int'($urandom_range(0, 2)); w++)
                cpu_write(13'($urandom), 8'($urandom));
            wait_tick();
            if ($urandom_range(0, 1) == 1) begin
                gap = $urandom_range(1, 3);
                q_ok.push_back(gap + 1);
                okout_pulse();
                for (int t = 0; t < gap; t++) wait_tick();
            end
            ak_seq = {};
            for (int t = 0; t < int'($urandom_range(0, 6)); t++) ak_seq.push_back(1'($urandom_range(0, 1)));
            for (int t = 0; t < SYNC; t++) ak_seq.push_back(1'b1);
            kend = req_end(0, g);
            drop = 0;
            if ($urandom_range(0, 3) == 0 && kend > 1) drop = $urandom_range(1, kend - 1);
            a = 13'($urandom);
            do_request(drop, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0, a);
        end

        repeat (4) wait_tick();
        check("pending_okout", q_ok.size(), 0);
        check("pending_grant", q_grant.size(), 0);
        check("pending_release", q_rel.size(), 0);
        check("pending_db", q_db.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
